// File: rtl/spi_slave_rx_mode.sv
// SPI slave receiver running entirely in the clk domain.
// The cs_n/sck/si pins are oversampled through a synchroniser chain. A
// further flop on synced sck/cs_n detects edges, and those edge pulses are
// registered together with the aligned data bit. A two-state FSM assembles
// words from that stage, and a final output register presents dout/qvld/frm_err.
// All four CPOL/CPHA modes are supported; the mode is latched at frame start.
module spi_slave_rx_mode #(
    parameter int DATA_LEN    = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_en,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                cs_n,
    input  logic                sck,
    input  logic                si,
    output logic [DATA_LEN-1:0] dout,
    output logic                qvld,
    output logic                frm_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(DATA_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // synchroniser chains, index 0 is the pin side
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] si_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    // registered edge pulses, aligned with the data bit they belong to
    logic sck_rise_q;
    logic sck_fall_q;
    logic cs_rise_q;
    logic cs_fall_q;
    logic si_q;

    // FSM state and word assembly
    state_t                state_q, state_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DATA_LEN-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_LEN-1:0]   word_q, word_d;

    // output register
    logic [DATA_LEN-1:0]   dout_q;
    logic                  qvld_q;
    logic                  frm_err_q;

    logic                  sck_s;
    logic                  cs_s;
    logic                  si_s;
    logic                  sample_edge;
    logic [DATA_LEN-1:0]   shift_in;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign si_s  = si_sync_q[SYNC_STAGES-1];

    // Sampling happens on the falling sck edge exactly when cpol and cpha
    // differ (mode 1: trailing=fall, mode 2: leading=fall), else on the rise.
    assign sample_edge = (cpol_q ^ cpha_q) ? sck_fall_q : sck_rise_q;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_in = {shift_q[DATA_LEN-2:0], si_q};
        end else begin : g_lsb_first
            assign shift_in = {si_q, shift_q[DATA_LEN-1:1]};
        end
    endgenerate

    // Synchronise the asynchronous pins; cs_n idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            si_sync_q  <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], si};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
        end
    end

    // Register edge pulses so that an sck edge and a cs_n edge reaching the
    // synchronised side together are seen by the FSM in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            si_q       <= 1'b0;
        end else begin
            sck_rise_q <= sck_s & ~sck_prev_q;
            sck_fall_q <= ~sck_s & sck_prev_q;
            cs_rise_q  <= cs_s & ~cs_prev_q;
            cs_fall_q  <= ~cs_s & cs_prev_q;
            si_q       <= si_s;
        end
    end

    // FSM next state: frame entry, bit shifting, word completion and frame end.
    always_comb begin
        state_d = state_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_q && rx_en) begin
                    state_d = ST_ACTIVE;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (!rx_en) begin
                    // abort silently; dout stays as it was
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    // the sample edge is processed before a coincident cs_n rise
                    if (sample_edge) begin
                        shift_d = shift_in;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                            word_d = shift_in;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (cs_rise_q) begin
                        err_d   = !done_d && (cnt_d != '0);
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and word-assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

    // Output register: dout changes only together with a qvld pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q    <= '0;
            qvld_q    <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            qvld_q    <= done_q;
            frm_err_q <= err_q;
            if (done_q) begin
                dout_q <= word_q;
            end
        end
    end

    assign dout    = dout_q;
    assign qvld    = qvld_q;
    assign frm_err = frm_err_q;
    assign busy    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx_mode.sv
// Bench for spi_slave_rx_mode: two instances (MSB-first and LSB-first) share
// one SPI bus. A stream-level model derives expected words from the bits sent.
module tb_spi_slave_rx_mode;

    localparam int DL = 8;
    localparam int SS = 2;
    localparam int H  = 4;   // clk cycles per sck half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_en = 1'b0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic cs_n = 1'b1;
    logic sck = 1'b0;
    logic si = 1'b0;
    logic [DL-1:0] dout_a, dout_b;
    logic qvld_a, qvld_b, frm_err_a, frm_err_b, busy_a, busy_b;

    always #5 clk = ~clk;

    spi_slave_rx_mode #(.DATA_LEN(DL), .SYNC_STAGES(SS), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rx_en(rx_en), .cpol(cpol), .cpha(cpha),
        .cs_n(cs_n), .sck(sck), .si(si),
        .dout(dout_a), .qvld(qvld_a), .frm_err(frm_err_a), .busy(busy_a)
    );

    spi_slave_rx_mode #(.DATA_LEN(DL), .SYNC_STAGES(SS), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rx_en(rx_en), .cpol(cpol), .cpha(cpha),
        .cs_n(cs_n), .sck(sck), .si(si),
        .dout(dout_b), .qvld(qvld_b), .frm_err(frm_err_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // observed events
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int ea = 0;
    int eb = 0;
    int both = 0;

    // model state
    bit stream[$];
    logic [7:0] exp_qa[$];
    logic [7:0] exp_qb[$];
    int exp_err;
    logic [7:0] mdout_a = 8'h00;
    logic [7:0] mdout_b = 8'h00;

    typedef struct {
        bit         pol;
        bit         ph;
        bit         lsb;
        int         nw;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         pbits;
        logic [7:0] pval;
        int         enq;
        int         eerr;
        logic [7:0] ed_a;
        logic [7:0] ed_b;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];

    always @(posedge clk) begin
        #1;
        if (qvld_a) qa.push_back(dout_a);
        if (qvld_b) qb.push_back(dout_b);
        if (frm_err_a) ea++;
        if (frm_err_b) eb++;
        if ((qvld_a && frm_err_a) || (qvld_b && frm_err_b)) both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        qa.delete();
        qb.delete();
        ea = 0;
        eb = 0;
    endtask

    task automatic send_bit(input bit b, input bit ph);
        if (!ph) begin
            si = b;
            wait_clk(H);
            sck = ~sck;
            wait_clk(H);
            sck = ~sck;
        end else begin
            sck = ~sck;
            si = b;
            wait_clk(H);
            sck = ~sck;
            wait_clk(H);
        end
    endtask

    // one cs_n frame carrying the current stream; mode inputs are scrambled mid-frame
    task automatic run_frame(input bit pol, input bit ph);
        clear_mon();
        cpol = pol;
        cpha = ph;
        sck = pol;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(6);
        cpol = 1'($urandom);
        cpha = 1'($urandom);
        for (int i = 0; i < stream.size(); i++) begin
            send_bit(stream[i], ph);
            if (i % 8 == 7) check("busy_word", busy_a, 1);
        end
        wait_clk(2);
        check("busy_end", busy_b, 1);
        cs_n = 1'b1;
        wait_clk(10);
    endtask

    // expected words: every 8 consecutive bits form one word; MSB-first puts
    // bit k of the word at position 7-k, LSB-first at position k
    task automatic build_model();
        logic [7:0] wa, wb;
        int pos;
        exp_qa.delete();
        exp_qb.delete();
        wa = '0;
        wb = '0;
        for (int i = 0; i < stream.size(); i++) begin
            pos = i % 8;
            wa[7-pos] = stream[i];
            wb[pos] = stream[i];
            if (pos == 7) begin
                exp_qa.push_back(wa);
                exp_qb.push_back(wb);
                wa = '0;
                wb = '0;
            end
        end
        exp_err = (stream.size() % 8 != 0) ? 1 : 0;
        if (exp_qa.size() > 0) begin
            mdout_a = exp_qa[exp_qa.size()-1];
            mdout_b = exp_qb[exp_qb.size()-1];
        end
    endtask

    task automatic compare_words(input string tag);
        for (int i = 0; i < exp_qa.size() && i < qa.size(); i++)
            check($sformatf("%s_word_a%0d", tag, i), qa[i], exp_qa[i]);
        for (int i = 0; i < exp_qb.size() && i < qb.size(); i++)
            check($sformatf("%s_word_b%0d", tag, i), qb[i], exp_qb[i]);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_nq_a"}, qa.size(), exp_qa.size());
        check({tag, "_nq_b"}, qb.size(), exp_qb.size());
        compare_words(tag);
        check({tag, "_err_a"}, ea, exp_err);
        check({tag, "_err_b"}, eb, exp_err);
        check({tag, "_dout_a"}, dout_a, mdout_a);
        check({tag, "_dout_b"}, dout_b, mdout_b);
        check({tag, "_overlap"}, both, 0);
        check({tag, "_busy_idle"}, busy_a, 0);
    endtask

    task automatic push_word(input logic [7:0] wv, input bit lsb);
        for (int b = 0; b < 8; b++) stream.push_back(lsb ? wv[b] : wv[7-b]);
    endtask

    initial begin
        logic [7:0] wv;
        int k;
        bit pol, ph;
        int nw, pb;

        tbl[0] = '{0, 0, 0, 1, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'hA5, 8'hA5};
        tbl[1] = '{0, 0, 0, 3, 8'h12, 8'h34, 8'h56, 0, 8'h00, 3, 0, 8'h56, 8'h6A};
        tbl[2] = '{1, 1, 0, 1, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 8'h3C};
        tbl[3] = '{0, 1, 0, 1, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 8'h3C};
        tbl[4] = '{1, 0, 0, 1, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 8'h3C};
        tbl[5] = '{0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 5, 8'hFF, 0, 1, 8'h3C, 8'h3C};
        tbl[6] = '{0, 0, 1, 1, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'hA5, 8'hA5};
        tbl[7] = '{0, 1, 0, 1, 8'hC1, 8'h00, 8'h00, 3, 8'hA0, 1, 1, 8'hC1, 8'h83};
        tbl[8] = '{1, 1, 0, 1, 8'h0F, 8'h00, 8'h00, 7, 8'hFE, 1, 1, 8'h0F, 8'hF0};

        // reset state
        wait_clk(3);
        check("rst_dout_a", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_qvld", qvld_a, 0);
        check("rst_frm_err", frm_err_a, 0);
        check("rst_busy", busy_a, 0);
        rst = 1'b0;
        rx_en = 1'b1;
        wait_clk(3);

        // table-driven frames
        for (int v = 0; v < NV; v++) begin
            stream.delete();
            for (int w = 0; w < tbl[v].nw; w++) begin
                wv = (w == 0) ? tbl[v].w0 : (w == 1) ? tbl[v].w1 : tbl[v].w2;
                push_word(wv, tbl[v].lsb);
            end
            for (int b = 0; b < tbl[v].pbits; b++) stream.push_back(tbl[v].pval[7-b]);
            run_frame(tbl[v].pol, tbl[v].ph);
            build_model();
            check($sformatf("tbl%0d_nq_a", v), qa.size(), tbl[v].enq);
            check($sformatf("tbl%0d_nq_b", v), qb.size(), tbl[v].enq);
            compare_words($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_err_a", v), ea, tbl[v].eerr);
            check($sformatf("tbl%0d_err_b", v), eb, tbl[v].eerr);
            check($sformatf("tbl%0d_dout_a", v), dout_a, tbl[v].ed_a);
            check($sformatf("tbl%0d_dout_b", v), dout_b, tbl[v].ed_b);
            check($sformatf("tbl%0d_overlap", v), both, 0);
            mdout_a = tbl[v].ed_a;
            mdout_b = tbl[v].ed_b;
            $display("vector %0d: mode %0d%0d words=%0d frm_err=%0d dout=0x%02h/0x%02h",
                     v, tbl[v].pol, tbl[v].ph, qa.size(), ea, dout_a, dout_b);
        end

        // qvld latency: edge 1 is the first posedge seeing the new sck level,
        // qvld must appear SS+2 edges after it
        stream.delete();
        push_word(8'h5A, 1'b0);
        clear_mon();
        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 7; i++) send_bit(stream[i], 1'b0);
        si = stream[7];
        wait_clk(H);
        sck = 1'b1;
        k = 1;
        while (k <= 20) begin
            @(posedge clk);
            #1;
            if (qvld_a) break;
            k++;
        end
        check("qvld_latency", k, SS + 3);
        wait_clk(H);
        sck = 1'b0;
        wait_clk(2);
        cs_n = 1'b1;
        wait_clk(10);
        build_model();
        compare_frame("latency");
        $display("latency: qvld on edge %0d, dout=0x%02h", k, dout_a);

        // last sample edge and cs_n rise reach the pins together (mode 1)
        stream.delete();
        push_word(8'h96, 1'b0);
        clear_mon();
        cpol = 1'b0; cpha = 1'b1; sck = 1'b0;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 7; i++) send_bit(stream[i], 1'b1);
        sck = ~sck;
        si = stream[7];
        wait_clk(H);
        sck = ~sck;
        cs_n = 1'b1;
        wait_clk(12);
        build_model();
        compare_frame("cs_same_clk");
        $display("cs_same_clk: words=%0d frm_err=%0d dout=0x%02h", qa.size(), ea, dout_a);

        // asynchronous reset after 4 bits, then a clean frame of 0x81
        clear_mon();
        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_dout_a", dout_a, 0);
        check("rst_mid_dout_b", dout_b, 0);
        check("rst_mid_busy", busy_a, 0);
        cs_n = 1'b1;
        wait_clk(3);
        check("rst_hold_qvld", qvld_a, 0);
        check("rst_hold_frm_err", frm_err_b, 0);
        rst = 1'b0;
        wait_clk(4);
        mdout_a = 8'h00;
        mdout_b = 8'h00;
        stream.delete();
        push_word(8'h81, 1'b0);
        run_frame(1'b0, 1'b0);
        build_model();
        compare_frame("after_rst");
        $display("after_rst: words=%0d frm_err=%0d dout=0x%02h", qa.size(), ea, dout_a);

        // rx_en dropped mid-frame of 0x77, re-enabled while cs_n still low
        stream.delete();
        push_word(8'h77, 1'b0);
        clear_mon();
        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 4; i++) send_bit(stream[i], 1'b0);
        rx_en = 1'b0;
        wait_clk(3);
        check("rxen_abort_busy", busy_a, 0);
        rx_en = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(stream[i], 1'b0);
        wait_clk(2);
        check("rxen_not_reentered", busy_a, 0);
        cs_n = 1'b1;
        wait_clk(10);
        check("rxen_nq", qa.size(), 0);
        check("rxen_err", ea, 0);
        check("rxen_dout_a", dout_a, mdout_a);
        check("rxen_dout_b", dout_b, mdout_b);
        $display("rx_en abort: words=%0d frm_err=%0d dout=0x%02h", qa.size(), ea, dout_a);

        // sck and si activity with cs_n high
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            sck = ~sck;
            si = 1'($urandom);
            wait_clk(2);
        end
        wait_clk(8);
        check("cs_high_nq", qa.size() + qb.size(), 0);
        check("cs_high_err", ea + eb, 0);
        check("cs_high_busy", busy_a, 0);
        $display("cs high noise: words=%0d frm_err=%0d", qa.size(), ea);

        // randomized frames against the stream model
        for (int r = 0; r < 40; r++) begin
            pol = 1'($urandom);
            ph = 1'($urandom);
            nw = $urandom_range(0, 3);
            pb = $urandom_range(0, 7);
            stream.delete();
            for (int w = 0; w < nw; w++) push_word(8'($urandom), 1'b0);
            for (int b = 0; b < pb; b++) stream.push_back(1'($urandom));
            run_frame(pol, ph);
            build_model();
            compare_frame($sformatf("rnd%0d", r));
            $display("random %0d: mode %0d%0d bits=%0d words=%0d frm_err=%0d dout=0x%02h",
                     r, pol, ph, stream.size(), qa.size(), ea, dout_a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "time limit");
    end

endmodule
